// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - decode/execute hazard signals between the pipeline and the hazard unit
// Optional perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_control_unit_if #(
  parameter int REG_ADDR_LEN = 5
`ifdef HAZARD_PERF_EN
  , parameter int PERF_WIDTH = 16
`endif
);
  logic [REG_ADDR_LEN-1:0] id_rs1;
  logic [REG_ADDR_LEN-1:0] id_rs2;
  logic                    id_uses_rs2;
  logic                    ex_mem_read;
  logic [REG_ADDR_LEN-1:0] ex_rd;
  logic                    branch_taken;
  logic                    imem_ready;
  logic                    pc_write;
  logic                    if_id_write;
  logic                    if_flush;
  logic                    id_ex_bubble;
`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0]   stall_count;
  logic [PERF_WIDTH-1:0]   flush_count;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, branch_taken, imem_ready,
    input  pc_write, if_id_write, if_flush, id_ex_bubble
`ifdef HAZARD_PERF_EN
    , input stall_count, flush_count
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, branch_taken, imem_ready,
    output pc_write, if_id_write, if_flush, id_ex_bubble
`ifdef HAZARD_PERF_EN
    , output stall_count, flush_count
`endif
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush control for load-use, taken branch and imem wait
// Optional stall/flush perf counters are built when HAZARD_PERF_EN is defined.
module hazard_control_unit #(
  parameter int REG_ADDR_LEN      = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
`ifdef HAZARD_PERF_EN
  , parameter int PERF_WIDTH      = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hz
);
  localparam int MAX_CYCLES = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [REG_ADDR_LEN-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    IMWAIT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use;
  logic          pc_write_c, if_id_write_c, if_flush_c, id_ex_bubble_c;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_flush_c     = 1'b0;
    id_ex_bubble_c = 1'b0;
    // A redirect discards whatever is in flight, so it overrides every state.
    if (hz.branch_taken) begin
      if_flush_c     = 1'b1;
      id_ex_bubble_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (!hz.imem_ready) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
      state_d        = IMWAIT;
      cnt_d          = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LDSTALL;
              cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
            end
          end
        end
        LDSTALL: begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          cnt_d          = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        FLUSH: begin
          if_flush_c     = 1'b1;
          id_ex_bubble_c = 1'b1;
          cnt_d          = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        IMWAIT: begin
          if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
          end
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.pc_write     = rst & pc_write_c;
  assign hz.if_id_write  = rst & if_id_write_c;
  assign hz.if_flush     = rst & if_flush_c;
  assign hz.id_ex_bubble = rst & id_ex_bubble_c;

`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (!pc_write_c && (stall_count_q != {PERF_WIDTH{1'b1}}))
        stall_count_q <= stall_count_q + PERF_WIDTH'(1);
      if (if_flush_c && (flush_count_q != {PERF_WIDTH{1'b1}}))
        flush_count_q <= flush_count_q + PERF_WIDTH'(1);
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed-vector bench for hazard_control_unit
// dut_a uses single-cycle stall/flush, dut_b uses LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2.
module tb_hazard_control_unit;
  localparam logic [3:0] ZERO  = 4'b0000;
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FL    = 4'b1111;

  typedef struct packed {
    logic       br;
    logic       rdy;
    logic       mr;
    logic       u2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       br, rdy, mr, u2;
  logic [4:0] rd, rs1, rs2;
  int         n_vec;
  int         n_err;

  hazard_control_unit_if #(.REG_ADDR_LEN(5)
`ifdef HAZARD_PERF_EN
    , .PERF_WIDTH(4)
`endif
  ) ifa ();
  hazard_control_unit_if #(.REG_ADDR_LEN(5)
`ifdef HAZARD_PERF_EN
    , .PERF_WIDTH(4)
`endif
  ) ifb ();

  hazard_control_unit #(.REG_ADDR_LEN(5), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)
`ifdef HAZARD_PERF_EN
    , .PERF_WIDTH(4)
`endif
  ) dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));

  hazard_control_unit #(.REG_ADDR_LEN(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)
`ifdef HAZARD_PERF_EN
    , .PERF_WIDTH(4)
`endif
  ) dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));

  assign ifa.branch_taken = br;  assign ifb.branch_taken = br;
  assign ifa.imem_ready   = rdy; assign ifb.imem_ready   = rdy;
  assign ifa.ex_mem_read  = mr;  assign ifb.ex_mem_read  = mr;
  assign ifa.id_uses_rs2  = u2;  assign ifb.id_uses_rs2  = u2;
  assign ifa.ex_rd        = rd;  assign ifb.ex_rd        = rd;
  assign ifa.id_rs1       = rs1; assign ifb.id_rs1       = rs1;
  assign ifa.id_rs2       = rs2; assign ifb.id_rs2       = rs2;

  wire [3:0] oa = {ifa.pc_write, ifa.if_id_write, ifa.if_flush, ifa.id_ex_bubble};
  wire [3:0] ob = {ifb.pc_write, ifb.if_id_write, ifb.if_flush, ifb.id_ex_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic b, logic r, logic m, logic u, logic [4:0] d,
                              logic [4:0] s1, logic [4:0] s2, logic [3:0] ea, logic [3:0] eb);
    vec_t v;
    v = '{br: b, rdy: r, mr: m, u2: u, rd: d, rs1: s1, rs2: s2, ea: ea, eb: eb};
    return v;
  endfunction

  function automatic vec_t idle(logic [3:0] ea, logic [3:0] eb);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ea, eb);
  endfunction

  function automatic vec_t lu(logic [3:0] ea, logic [3:0] eb);
    return mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, ea, eb);
  endfunction

  task automatic apply(vec_t v);
    br = v.br; rdy = v.rdy; mr = v.mr; u2 = v.u2;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      br = i[0]; rdy = i[1]; mr = 1'b1; u2 = i[2];
      rd = 5'd5; rs1 = 5'd5; rs2 = 5'(i);
      #3;
      n_vec++;
      if (oa !== ZERO) begin n_err++; $display("FAIL reset_hold[%0d] dut_a got %b expected %b", i, oa, ZERO); end
      n_vec++;
      if (ob !== ZERO) begin n_err++; $display("FAIL reset_hold[%0d] dut_b got %b expected %b", i, ob, ZERO); end
    end
    @(posedge clk); #1;
    apply(idle(NORM, NORM));
    rst = 1'b1;
    #2;
    n_vec++;
    if (oa !== NORM) begin n_err++; $display("FAIL reset_release dut_a got %b expected %b", oa, NORM); end
    n_vec++;
    if (ob !== NORM) begin n_err++; $display("FAIL reset_release dut_b got %b expected %b", ob, NORM); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    vec_t v[$];
    v.push_back(lu(STALL, STALL));
    v.push_back(idle(NORM, STALL));
    v.push_back(idle(NORM, STALL));
    v.push_back(idle(NORM, NORM));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, NORM, NORM));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd5, NORM, NORM));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd3, 5'd5, STALL, STALL));
    v.push_back(idle(NORM, STALL));
    v.push_back(idle(NORM, STALL));
    v.push_back(idle(NORM, NORM));
    foreach (v[i]) begin
      apply(v[i]); #2;
      n_vec++;
      if (oa !== v[i].ea) begin n_err++; $display("FAIL load_use[%0d] dut_a got %b expected %b", i, oa, v[i].ea); end
      n_vec++;
      if (ob !== v[i].eb) begin n_err++; $display("FAIL load_use[%0d] dut_b got %b expected %b", i, ob, v[i].eb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    v.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, FL, FL));
    v.push_back(idle(NORM, FL));
    v.push_back(idle(NORM, NORM));
    foreach (v[i]) begin
      apply(v[i]); #2;
      n_vec++;
      if (oa !== v[i].ea) begin n_err++; $display("FAIL branch[%0d] dut_a got %b expected %b", i, oa, v[i].ea); end
      n_vec++;
      if (ob !== v[i].eb) begin n_err++; $display("FAIL branch[%0d] dut_b got %b expected %b", i, ob, v[i].eb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imem_wait();
    vec_t v[$];
    vec_t nr;
    nr = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, STALL, STALL);
    v.push_back(nr);
    v.push_back(nr);
    v.push_back(nr);
    v.push_back(idle(NORM, NORM));
    v.push_back(idle(NORM, NORM));
    v.push_back(nr);
    v.push_back(lu(STALL, STALL));
    v.push_back(idle(NORM, NORM));
    foreach (v[i]) begin
      apply(v[i]); #2;
      n_vec++;
      if (oa !== v[i].ea) begin n_err++; $display("FAIL imem_wait[%0d] dut_a got %b expected %b", i, oa, v[i].ea); end
      n_vec++;
      if (ob !== v[i].eb) begin n_err++; $display("FAIL imem_wait[%0d] dut_b got %b expected %b", i, ob, v[i].eb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    vec_t v[$];
    v.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, FL, FL));
    v.push_back(idle(NORM, FL));
    v.push_back(idle(NORM, NORM));
    v.push_back(lu(STALL, STALL));
    v.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, FL, FL));
    v.push_back(idle(NORM, FL));
    v.push_back(idle(NORM, NORM));
    v.push_back(lu(STALL, STALL));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, STALL, STALL));
    v.push_back(idle(NORM, NORM));
    v.push_back(idle(NORM, NORM));
    foreach (v[i]) begin
      apply(v[i]); #2;
      n_vec++;
      if (oa !== v[i].ea) begin n_err++; $display("FAIL simultaneous[%0d] dut_a got %b expected %b", i, oa, v[i].ea); end
      n_vec++;
      if (ob !== v[i].eb) begin n_err++; $display("FAIL simultaneous[%0d] dut_b got %b expected %b", i, ob, v[i].eb); end
      @(posedge clk); #1;
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    apply(idle(NORM, NORM));
    rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, FL, FL));
    @(posedge clk); #1;
    apply(idle(NORM, NORM));
    @(posedge clk); #1;
    n_vec++;
    if (ifa.flush_count !== 4'd1) begin n_err++; $display("FAIL perf_flush dut_a got %0d expected 1", ifa.flush_count); end
    n_vec++;
    if (ifb.flush_count !== 4'd2) begin n_err++; $display("FAIL perf_flush dut_b got %0d expected 2", ifb.flush_count); end
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    n_vec++;
    if (ifa.stall_count !== 4'd15) begin n_err++; $display("FAIL perf_stall_sat dut_a got %0d expected 15", ifa.stall_count); end
    n_vec++;
    if (ifb.stall_count !== 4'd15) begin n_err++; $display("FAIL perf_stall_sat dut_b got %0d expected 15", ifb.stall_count); end
    rst = 1'b0; #2;
    n_vec++;
    if (ifa.stall_count !== 4'd0) begin n_err++; $display("FAIL perf_reset dut_a got %0d expected 0", ifa.stall_count); end
    n_vec++;
    if (ifb.flush_count !== 4'd0) begin n_err++; $display("FAIL perf_reset dut_b got %0d expected 0", ifb.flush_count); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    apply(idle(NORM, NORM));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch();
    test_imem_wait();
    test_simultaneous();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
